// File: rtl/popcount_pipe.sv
// rtl/popcount_pipe.sv - pipelined parametrised population-count engine
//
// Purpose: counts the set bits of a WIDTH-bit beat. Stage 1 is a bank of
// 6:3 compressor cells (one per 6-bit group, top group zero-padded); the
// following stages form a registered binary adder tree. Latency is
// 1 + ceil(log2(ceil(WIDTH/6))) cycles, throughput one beat per cycle.
//
// Optional feature macro: POPCNT_ACCUM_EN (adds a saturating per-packet
// accumulator with in_last / acc_valid / acc_count).
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous reset, active-high
//   in_valid   in   input beat valid
//   in_ready   out  pipeline accepts a beat this cycle
//   in_data    in   [WIDTH] vector to count
//   in_last    in   last beat of a packet      (POPCNT_ACCUM_EN only)
//   acc_valid  out  one-cycle packet-sum pulse (POPCNT_ACCUM_EN only)
//   acc_count  out  [ACCW] saturated packet sum (POPCNT_ACCUM_EN only)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   out_count  out  [clog2(WIDTH+1)] popcount of the beat
module popcount_pipe #(
  parameter int WIDTH = 36,
  parameter int ACCW  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
`ifdef POPCNT_ACCUM_EN
  input  logic                         in_last,
  output logic                         acc_valid,
  output logic [ACCW-1:0]              acc_count,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   out_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int G  = (WIDTH + 5) / 6;
  localparam int T  = $clog2(G);
  // One uniform element width for every tree level: wide enough for a group
  // count (3 bits) and for the final total, so no level can overflow.
  localparam int SW = (CW > 3) ? CW : 3;

  // Number of live elements at tree level lv.
  function automatic int lvl_n(input int lv);
    return (G + (1 << lv) - 1) >> lv;
  endfunction

  // 6:3 compressor cell: number of ones among six bits.
  function automatic logic [2:0] cmp63(input logic [5:0] b);
    return {2'b00, b[0]} + {2'b00, b[1]} + {2'b00, b[2]} +
           {2'b00, b[3]} + {2'b00, b[4]} + {2'b00, b[5]};
  endfunction

  logic [SW-1:0] lvl_q [T+1][G];
  logic [SW-1:0] lvl_d [T+1][G];
  logic [T:0]    vld_q, vld_d;
  logic [6*G-1:0] padded;
  logic          adv;

  assign out_valid = vld_q[T];
  assign out_count = lvl_q[T][0][CW-1:0];
  // The whole pipe moves together; it only stalls when a result is waiting.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  // Idle beats are forced to zero so in_data never leaks into out_count.
  always_comb begin
    padded = '0;
    if (in_valid) padded[WIDTH-1:0] = in_data;
  end

  always_comb begin
    for (int lv = 0; lv <= T; lv++) begin
      for (int k = 0; k < G; k++) lvl_d[lv][k] = '0;
    end
    for (int k = 0; k < G; k++) lvl_d[0][k] = SW'(cmp63(padded[6*k +: 6]));
    for (int lv = 1; lv <= T; lv++) begin
      for (int k = 0; k < G; k++) begin
        if (k < lvl_n(lv)) begin
          // Odd trailing element is forwarded unchanged.
          if (2*k + 1 < lvl_n(lv - 1))
            lvl_d[lv][k] = lvl_q[lv-1][2*k] + lvl_q[lv-1][2*k+1];
          else
            lvl_d[lv][k] = lvl_q[lv-1][2*k];
        end
      end
    end
    vld_d    = '0;
    vld_d[0] = in_valid & in_ready;
    for (int lv = 1; lv <= T; lv++) vld_d[lv] = vld_q[lv-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int lv = 0; lv <= T; lv++) begin
        for (int k = 0; k < G; k++) lvl_q[lv][k] <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_d;
      lvl_q <= lvl_d;
    end
  end

`ifdef POPCNT_ACCUM_EN
  localparam int AW = ((ACCW > CW) ? ACCW : CW) + 1;

  logic [T:0]      lst_q, lst_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] acc_count_q, acc_count_d;
  logic            acc_valid_q, acc_valid_d;
  logic [AW-1:0]   acc_sum;

  assign acc_valid = acc_valid_q;
  assign acc_count = acc_count_q;

  always_comb begin
    lst_d    = '0;
    lst_d[0] = in_last;
    for (int lv = 1; lv <= T; lv++) lst_d[lv] = lst_q[lv-1];
  end

  always_comb begin
    // One spare bit lets the saturation test see the carry.
    acc_sum = AW'(acc_q) + AW'(out_count);
    if (acc_sum > AW'({ACCW{1'b1}})) acc_sum = AW'({ACCW{1'b1}});
    acc_d       = acc_q;
    acc_count_d = acc_count_q;
    acc_valid_d = 1'b0;
    if (out_valid && out_ready) begin
      if (lst_q[T]) begin
        acc_count_d = acc_sum[ACCW-1:0];
        acc_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = acc_sum[ACCW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lst_q       <= '0;
      acc_q       <= '0;
      acc_count_q <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      if (adv) lst_q <= lst_d;
      acc_q       <= acc_d;
      acc_count_q <= acc_count_d;
      acc_valid_q <= acc_valid_d;
    end
  end
`endif

endmodule
